// File: rtl/hack_rom_loader.sv
// hack_rom_loader: framed byte-stream loader that writes 16-bit Hack words into the instruction ROM.
module hack_rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, FAIL} state_t;
  localparam logic [16:0] cap = 17'd1 << ADDR_W;
  state_t state, state_n;
  logic [15:0] len, len_rx;
  logic [7:0] hi, acc;
  logic [ADDR_W:0] idx;
  logic accept, launch, last;
  assign accept = rx_valid && rx_ready;
  assign busy = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
  assign launch = start && !busy;
  assign len_rx = {len[15:8], rx_data};
  assign last = 17'(idx) + 17'd1 == {1'b0, len};
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, FAIL: state_n = launch ? LEN_HI : state;
      LEN_HI:  state_n = accept ? LEN_LO : state;
      LEN_LO:  state_n = !accept ? state : ({1'b0, len_rx} > cap) ? FAIL : (len_rx == 16'd0) ? CHECK : DATA_HI;
      DATA_HI: state_n = accept ? DATA_LO : state;
      DATA_LO: state_n = !accept ? state : last ? CHECK : DATA_HI;
      CHECK:   state_n = !accept ? state : (rx_data == acc) ? DONE : FAIL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      rx_ready  <= 1'b0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      len       <= '0;
      hi        <= '0;
      acc       <= '0;
      idx       <= '0;
    end else begin
      rx_ready <= state_n inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
      rom_we   <= 1'b0;
      if (launch) begin
        done      <= 1'b0;
        error     <= 1'b0;
        cpu_reset <= 1'b1;
        idx       <= '0;
        acc       <= '0;
      end
      if (accept && state != CHECK) acc <= acc + rx_data;
      if (accept && state == LEN_HI) len[15:8] <= rx_data;
      if (accept && state == LEN_LO) len <= len_rx;
      if (accept && state == DATA_HI) hi <= rx_data;
      if (accept && state == DATA_LO) begin
        rom_we    <= 1'b1;
        rom_addr  <= idx[ADDR_W-1:0];
        rom_wdata <= {hi, rx_data};
        idx       <= idx + (ADDR_W+1)'(1);
      end
      if (state == CHECK && state_n == DONE) begin
        done      <= 1'b1;
        cpu_reset <= 1'b0;
      end
      if (state != FAIL && state_n == FAIL) error <= 1'b1;
    end
endmodule
